// File: rtl/div_iter.sv
// RV32M DIV/DIVU/REM/REMU execution stage: 32-cycle restoring division on operand
// magnitudes, with divide-by-zero and signed-overflow results resolved at accept.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] div_out,
    output logic [4:0]      rd_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    logic [1:0]      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            neg1_q, neg1_d;
    logic            neg2_q, neg2_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] div_out_q, div_out_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic            done_q, done_d;

    logic            signed_op;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] abs1, abs2;
    logic [XLEN:0]   rem_shift;
    logic            ge;
    logic [XLEN-1:0] quo_fix, rem_fix;

    always_comb begin
        signed_op = ~funct3[0];
        a_neg     = signed_op & rs1_value[XLEN-1];
        b_neg     = signed_op & rs2_value[XLEN-1];
        abs1      = a_neg ? (~rs1_value + 1'b1) : rs1_value;
        abs2      = b_neg ? (~rs2_value + 1'b1) : rs2_value;

        // Remainder stays below the divisor, so the low XLEN bits of the difference are exact.
        rem_shift = {rem_q, dvd_q[XLEN-1]};
        ge        = rem_shift >= {1'b0, dvs_q};

        quo_fix   = (!is_rem_q && (neg1_q ^ neg2_q)) ? (~dvd_q + 1'b1) : dvd_q;
        rem_fix   = (is_rem_q && neg1_q) ? (~rem_q + 1'b1) : rem_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        rd_d      = rd_q;
        div_out_d = div_out_q;
        rd_out_d  = rd_out_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && funct3[2]) begin
                    is_rem_d = funct3[1];
                    neg1_d   = a_neg;
                    neg2_d   = b_neg;
                    rd_d     = rd_in;
                    if (rs2_value == '0) begin
                        div_out_d = funct3[1] ? rs1_value : ALL_ONE;
                        rd_out_d  = rd_in;
                        state_d   = S_DONE;
                    end else if (signed_op && rs1_value == INT_MIN && rs2_value == ALL_ONE) begin
                        div_out_d = funct3[1] ? '0 : INT_MIN;
                        rd_out_d  = rd_in;
                        state_d   = S_DONE;
                    end else begin
                        dvd_d   = abs1;
                        dvs_d   = abs2;
                        rem_d   = '0;
                        cnt_d   = 5'd31;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // Dividend register doubles as the quotient: bits shift out MSB-first, quotient bits enter at LSB.
                rem_d = ge ? (rem_shift[XLEN-1:0] - dvs_q) : rem_shift[XLEN-1:0];
                dvd_d = {dvd_q[XLEN-2:0], ge};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    cnt_d   = 5'd0;
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                div_out_d = is_rem_q ? rem_fix : quo_fix;
                rd_out_d  = rd_q;
                state_d   = S_DONE;
            end
            default: begin
                // One quiet cycle, then the pulse cycle; start is ignored throughout.
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
        endcase

        if (flush) begin
            state_d   = S_IDLE;
            done_d    = 1'b0;
            div_out_d = div_out_q;
            rd_out_d  = rd_out_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            rd_q      <= '0;
            div_out_q <= '0;
            rd_out_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            rd_q      <= rd_d;
            div_out_q <= div_out_d;
            rd_out_q  <= rd_out_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign div_out = div_out_q;
    assign rd_out  = rd_out_q;

endmodule
